w5300_seq: RTL

Bus-cycle sequencer for the W5300 8-bit host interface. It takes single-byte access requests from the Z80-side decode logic and turns them into correctly timed /CS, /RD and /WR cycles. Z80 requests already arrive with the W5300 address mapped and A0-corrected. Optionally, it shares the bus with an internal interrupt-register poller and arbitrates between the two.

---
 rtl/w5300_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/w5300_seq.sv
// W5300 8-bit host-interface bus-cycle sequencer: times /CS, /RD, /WR for Z80 byte accesses.
// Optional interrupt-register poller and Z80/poller arbitration enabled by `define W5300_SEQ_POLL_EN.
module w5300_seq #(
    parameter int          SETUP_CYC   = 1,
    parameter int          STROBE_CYC  = 4,
    parameter int          HOLD_CYC    = 1,
    parameter int          POLL_PERIOD = 1024,
    parameter logic [9:0]  POLL_ADDR   = 10'h003
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        z_req,
    input  logic        z_wr,
    input  logic [9:0]  z_addr,
    input  logic [7:0]  z_wdata,
    output logic        z_ack,
    output logic [7:0]  z_rdata,
    output logic [9:0]  w_addr,
    output logic        w_cs_n,
    output logic        w_rd_n,
    output logic        w_wr_n,
    output logic [7:0]  w_dout,
    output logic        w_doe,
    input  logic [7:0]  w_din,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        dir_r, dir_s;
    logic        own_poll_r;
    logic        grant_z_s, grant_p_s;
    logic        cap_s, done_s;

`ifdef W5300_SEQ_POLL_EN
    localparam int PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    logic [PW-1:0] poll_cnt_r;
    logic          poll_pend_r;
    logic [7:0]    poll_reg_r;
`else
    logic          unused_poll_cfg_s;

    // Poller parameters are accepted for drop-in compatibility but have no effect here.
    assign unused_poll_cfg_s = (POLL_PERIOD > 0);
`endif

    // Owner selection; a still-high z_req during the ack cycle is stale and must not start a cycle.
    always_comb begin
        grant_z_s = (state_r == IDLE) && !z_ack && z_req;
`ifdef W5300_SEQ_POLL_EN
        grant_p_s = (state_r == IDLE) && !z_ack && !z_req && poll_pend_r;
`else
        grant_p_s = 1'b0;
`endif
        if (grant_z_s) begin
            dir_s = z_wr;
        end else if (grant_p_s) begin
            dir_s = 1'b0;
        end else begin
            dir_s = dir_r;
        end
    end

    // Next-state and phase counter: each state lasts N cycles, counter loads N-1 on entry.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cap_s   = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_z_s || grant_p_s) begin
                    state_s = SETUP;
                    cnt_s   = SETUP_LD;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == 4'd0) begin
                    state_s = STROBE;
                    cnt_s   = STROBE_LD;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s = HOLD;
                    cnt_s   = HOLD_LD;
                    cap_s   = !dir_r;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_r == 4'd0) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, holding registers and bus strobes; strobes are decoded from the next state so they are registered.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            dir_r      <= 1'b0;
            own_poll_r <= 1'b0;
            w_addr     <= 10'd0;
            w_dout     <= 8'd0;
            w_cs_n     <= 1'b1;
            w_rd_n     <= 1'b1;
            w_wr_n     <= 1'b1;
            w_doe      <= 1'b0;
            z_ack      <= 1'b0;
            z_rdata    <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dir_r   <= dir_s;
            if (grant_z_s) begin
                own_poll_r <= 1'b0;
                w_addr     <= z_addr;
                w_dout     <= z_wr ? z_wdata : w_dout;
            end else if (grant_p_s) begin
                own_poll_r <= 1'b1;
                w_addr     <= POLL_ADDR;
            end
            w_cs_n  <= (state_s == IDLE);
            w_rd_n  <= !((state_s == STROBE) && !dir_s);
            w_wr_n  <= !((state_s == STROBE) && dir_s);
            w_doe   <= (state_s != IDLE) && dir_s;
            z_ack   <= done_s && !own_poll_r;
            if (cap_s && !own_poll_r) begin
                z_rdata <= w_din;
            end
        end
    end

`ifdef W5300_SEQ_POLL_EN
    // Poll timer; a wrap while a poll is still pending is absorbed so at most one poll is outstanding.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_r  <= '0;
            poll_pend_r <= 1'b0;
            poll_reg_r  <= 8'd0;
            irq         <= 1'b0;
        end else begin
            poll_cnt_r <= (poll_cnt_r == POLL_LAST) ? '0 : poll_cnt_r + 1'b1;
            if (poll_cnt_r == POLL_LAST) begin
                poll_pend_r <= 1'b1;
            end else if (grant_p_s) begin
                poll_pend_r <= 1'b0;
            end
            if (cap_s && own_poll_r) begin
                poll_reg_r <= w_din;
            end
            if (done_s && own_poll_r) begin
                irq <= (poll_reg_r != 8'd0);
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule
